// File: rtl/mem_stage.sv
// Memory-access stage: issues data-bus requests with a valid/addr_ok/data_ok
// handshake, stalls while a transaction is outstanding, extracts load data and
// presents the values the W pipeline register latches.
module mem_stage #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m_valid,
    input  logic              m_flush,
    input  logic [31:0]       m_pc,
    input  logic [5:0]        m_icode,
    input  logic [5:0]        m_acode,
    input  logic [31:0]       m_val,
    input  logic [31:0]       m_val2,
    input  logic [4:0]        m_dst,
    input  logic [3:0]        m_write_enable,
    input  logic [3:0]        m_mem_op,
    output logic              dreq_valid,
    output logic              dreq_write,
    output logic [ADDR_W-1:0] dreq_addr,
    output logic [1:0]        dreq_size,
    output logic [3:0]        dreq_strobe,
    output logic [31:0]       dreq_data,
    input  logic              dresp_addr_ok,
    input  logic              dresp_data_ok,
    input  logic [31:0]       dresp_data,
    output logic              m_stall,
    output logic              W_bubble,
    output logic              m_addr_err,
    output logic [31:0]       W_val3,
    output logic [31:0]       W_pc,
    output logic [5:0]        W_acode,
    output logic [5:0]        W_icode,
    output logic [4:0]        W_dst,
    output logic [3:0]        W_write_enable
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_write;
    logic [1:0]         r_size;
    logic [3:0]         r_strobe;
    logic [31:0]        r_data;
    logic [31:0]        r_ldata;

    logic               w_is_load;
    logic               w_is_store;
    logic [1:0]         w_size;
    logic [3:0]         w_strobe;
    logic [31:0]        w_sdata;
    logic               w_misalign;
    logic               w_valid_op;
    logic               w_active;
    logic               w_req_v;
    logic               w_stall;
    logic               w_err;
    logic               w_use_reg;
    logic [31:0]        w_word;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_load_res;

    // Decode the memory op into size, strobes and lane-replicated store data
    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_size     = SZ_B;
        w_strobe   = 4'b0000;
        w_sdata    = 32'h0;
        case (m_mem_op)
            OP_LB, OP_LBU: w_is_load = 1'b1;
            OP_LH, OP_LHU: begin w_is_load = 1'b1; w_size = SZ_H; end
            OP_LW:         begin w_is_load = 1'b1; w_size = SZ_W; end
            OP_SB: begin
                w_is_store = 1'b1;
                w_strobe   = 4'b0001 << m_val[1:0];
                w_sdata    = {4{m_val2[7:0]}};
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_size     = SZ_H;
                w_strobe   = 4'b0011 << {m_val[1], 1'b0};
                w_sdata    = {2{m_val2[15:0]}};
            end
            OP_SW: begin
                w_is_store = 1'b1;
                w_size     = SZ_W;
                w_strobe   = 4'b1111;
                w_sdata    = m_val2;
            end
            default: ;
        endcase
    end

    assign w_misalign = ((w_size == SZ_H) && m_val[0]) ||
                        ((w_size == SZ_W) && (m_val[1:0] != 2'b00));
    assign w_valid_op = m_valid && !m_flush && (w_is_load || w_is_store);
    assign w_active   = w_valid_op && !w_misalign;

    // State, captured request fields and load capture register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= 2'd0;
            r_strobe <= 4'd0;
            r_data   <= 32'h0;
            r_ldata  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_active) begin
                r_addr   <= ADDR_W'(m_val);
                r_write  <= w_is_store;
                r_size   <= w_size;
                r_strobe <= w_strobe;
                r_data   <= w_sdata;
            end
            if (dresp_data_ok && r_state != S_DRAIN) begin
                r_ldata <= dresp_data;
            end
        end
    end

    // Handshake FSM: next state, request valid and stall
    always_comb begin
        w_next    = r_state;
        w_req_v   = 1'b0;
        w_stall   = 1'b0;
        w_err     = 1'b0;
        w_use_reg = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_err = w_valid_op && w_misalign;
                if (w_active) begin
                    w_req_v = 1'b1;
                    if (!(dresp_addr_ok && dresp_data_ok)) begin
                        w_stall = 1'b1;
                        w_next  = dresp_addr_ok ? S_WAIT : S_REQ;
                    end
                end
            end
            S_REQ: begin
                w_use_reg = 1'b1;
                if (m_flush) begin
                    // an accept racing the flush still owes us a response
                    if (dresp_addr_ok) begin
                        w_stall = 1'b1;
                        w_next  = S_DRAIN;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else begin
                    w_req_v = 1'b1;
                    if (dresp_addr_ok && dresp_data_ok) begin
                        w_next = S_IDLE;
                    end else begin
                        w_stall = 1'b1;
                        if (dresp_addr_ok) w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    w_next = S_IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (m_flush) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // hold the pipe until the orphaned response is swallowed
                w_stall = 1'b1;
                if (dresp_data_ok) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign dreq_valid  = resetn && w_req_v;
    assign m_stall     = resetn && w_stall;
    assign W_bubble    = resetn && w_stall;
    assign m_addr_err  = resetn && w_err;
    assign dreq_addr   = w_use_reg ? r_addr   : ADDR_W'(m_val);
    assign dreq_write  = w_use_reg ? r_write  : w_is_store;
    assign dreq_size   = w_use_reg ? r_size   : w_size;
    assign dreq_strobe = w_use_reg ? r_strobe : w_strobe;
    assign dreq_data   = w_use_reg ? r_data   : w_sdata;

    // Lane select and sign/zero extension of the returned load word
    always_comb begin
        w_word = dresp_data_ok ? dresp_data : r_ldata;
        case (m_val[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half = m_val[1] ? w_word[31:16] : w_word[15:0];
        case (m_mem_op)
            OP_LB:   w_load_res = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_load_res = {24'h0, w_byte};
            OP_LH:   w_load_res = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_load_res = {16'h0, w_half};
            default: w_load_res = w_word;
        endcase
    end

    // Result and register write enables for the W register
    always_comb begin
        W_val3         = m_val;
        W_write_enable = m_write_enable;
        if (!m_valid || m_flush) begin
            W_write_enable = 4'b0000;
        end else if (w_is_load || w_is_store) begin
            W_write_enable = 4'b0000;
            if (w_is_load && !w_misalign) begin
                W_val3         = w_load_res;
                W_write_enable = 4'b1111;
            end
        end
    end

    assign W_pc    = m_pc;
    assign W_icode = m_icode;
    assign W_acode = m_acode;
    assign W_dst   = m_dst;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with queued expectations for bus requests and
// W-stage results, checked by an independent monitor.
module tb_mem_stage;
    logic        clk;
    logic        resetn;
    logic        m_valid, m_flush;
    logic [31:0] m_pc, m_val, m_val2;
    logic [5:0]  m_icode, m_acode;
    logic [4:0]  m_dst;
    logic [3:0]  m_write_enable, m_mem_op;
    logic        dreq_valid, dreq_write;
    logic [31:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic [3:0]  dreq_strobe;
    logic [31:0] dreq_data;
    logic        dresp_addr_ok, dresp_data_ok;
    logic [31:0] dresp_data;
    logic        m_stall, W_bubble, m_addr_err;
    logic [31:0] W_val3, W_pc;
    logic [5:0]  W_acode, W_icode;
    logic [4:0]  W_dst;
    logic [3:0]  W_write_enable;

    typedef struct packed {
        logic [31:0] val3;
        logic [3:0]  we;
        logic        chk_val;
    } w_exp_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic        chk_data;
    } req_exp_t;

    w_exp_t   w_q[$];
    req_exp_t req_q[$];
    int checks = 0;
    int errors = 0;

    mem_stage #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_flush(m_flush), .m_pc(m_pc),
        .m_icode(m_icode), .m_acode(m_acode), .m_val(m_val), .m_val2(m_val2),
        .m_dst(m_dst), .m_write_enable(m_write_enable), .m_mem_op(m_mem_op),
        .dreq_valid(dreq_valid), .dreq_write(dreq_write), .dreq_addr(dreq_addr),
        .dreq_size(dreq_size), .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
        .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok),
        .dresp_data(dresp_data),
        .m_stall(m_stall), .W_bubble(W_bubble), .m_addr_err(m_addr_err),
        .W_val3(W_val3), .W_pc(W_pc), .W_acode(W_acode), .W_icode(W_icode),
        .W_dst(W_dst), .W_write_enable(W_write_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_valid       = 1'b0;
        m_flush       = 1'b0;
        m_mem_op      = 4'd0;
        dresp_addr_ok = 1'b0;
        dresp_data_ok = 1'b0;
        dresp_data    = 32'h0;
    endtask

    // Single-cycle transaction: bus accepts and answers in the issue cycle
    task automatic quick_op(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] val2, input logic [31:0] rdata,
                            input w_exp_t we, input req_exp_t re);
        m_valid = 1'b1; m_mem_op = op; m_val = addr; m_val2 = val2;
        dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1; dresp_data = rdata;
        w_q.push_back(we);
        req_q.push_back(re);
        @(negedge clk);
        chk("quick_stall", 32'(m_stall), 32'd0);
        next_cycle();
        idle_inputs();
    endtask

    // Monitor: pop and compare whenever a request is accepted or W latches a result
    always @(negedge clk) begin
        if (resetn) begin
            if (dreq_valid && dresp_addr_ok) begin
                if (req_q.size() == 0) begin
                    chk("req_unexpected", 32'd1, 32'd0);
                end else begin
                    req_exp_t r;
                    r = req_q.pop_front();
                    chk("req_write", 32'(dreq_write), 32'(r.write));
                    chk("req_addr", dreq_addr, r.addr);
                    chk("req_size", 32'(dreq_size), 32'(r.size));
                    chk("req_strobe", 32'(dreq_strobe), 32'(r.strobe));
                    if (r.chk_data) chk("req_data", dreq_data, r.data);
                end
            end
            if (m_valid && !m_flush && !m_stall) begin
                if (w_q.size() == 0) begin
                    chk("w_unexpected", 32'd1, 32'd0);
                end else begin
                    w_exp_t w;
                    w = w_q.pop_front();
                    chk("w_we", 32'(W_write_enable), 32'(w.we));
                    if (w.chk_val) chk("w_val3", W_val3, w.val3);
                end
            end
        end
    end

    initial begin
        int stall_cnt;
        int bub_cnt;
        resetn = 1'b0;
        m_pc = 32'h0; m_icode = 6'd0; m_acode = 6'd0; m_dst = 5'd0;
        m_write_enable = 4'd0; m_val = 32'h0; m_val2 = 32'h0;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rst_stall", 32'(m_stall), 32'd0);
        chk("rst_bubble", 32'(W_bubble), 32'd0);
        chk("rst_addr_err", 32'(m_addr_err), 32'd0);
        next_cycle();
        resetn = 1'b1;
        next_cycle();

        // LB at byte lane 3, sign-extended
        quick_op(4'd1, 32'h1003, 32'h0, 32'h80FF_FF7F,
                 w_exp_t'{32'hFFFF_FF80, 4'hF, 1'b1},
                 req_exp_t'{1'b0, 32'h1003, 2'd0, 4'h0, 32'h0, 1'b0});

        // LHU with addr_ok two cycles late and data_ok three cycles after that
        m_valid = 1'b1; m_mem_op = 4'd4; m_val = 32'h2002;
        stall_cnt = 0; bub_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            dresp_addr_ok = (c == 2);
            dresp_data_ok = (c == 5);
            dresp_data    = (c == 5) ? 32'hBEEF_1234 : 32'h0;
            if (c == 2) req_q.push_back(req_exp_t'{1'b0, 32'h2002, 2'd1, 4'h0, 32'h0, 1'b0});
            if (c == 5) w_q.push_back(w_exp_t'{32'h0000_BEEF, 4'hF, 1'b1});
            @(negedge clk);
            chk("lhu_dreq_valid", 32'(dreq_valid), 32'(c < 3));
            if (c < 3) begin
                chk("lhu_hold_addr", dreq_addr, 32'h2002);
                chk("lhu_hold_size", 32'(dreq_size), 32'd1);
            end
            stall_cnt += int'(m_stall);
            bub_cnt   += int'(W_bubble);
            next_cycle();
        end
        idle_inputs();
        chk("lhu_stall_cycles", 32'(stall_cnt), 32'd5);
        chk("lhu_bubble_cycles", 32'(bub_cnt), 32'd5);

        // Stores: byte, upper half, word
        quick_op(4'd6, 32'h10, 32'h0000_00AB, 32'h0,
                 w_exp_t'{32'h0, 4'h0, 1'b0},
                 req_exp_t'{1'b1, 32'h10, 2'd0, 4'b0001, 32'hABAB_ABAB, 1'b1});
        quick_op(4'd7, 32'h1E, 32'h1234_CDEF, 32'h0,
                 w_exp_t'{32'h0, 4'h0, 1'b0},
                 req_exp_t'{1'b1, 32'h1E, 2'd1, 4'b1100, 32'hCDEF_CDEF, 1'b1});
        quick_op(4'd8, 32'h20, 32'hCAFE_F00D, 32'h0,
                 w_exp_t'{32'h0, 4'h0, 1'b0},
                 req_exp_t'{1'b1, 32'h20, 2'd2, 4'b1111, 32'hCAFE_F00D, 1'b1});

        // LH upper half, sign-extended
        quick_op(4'd3, 32'h3002, 32'h0, 32'h8001_0000,
                 w_exp_t'{32'hFFFF_8001, 4'hF, 1'b1},
                 req_exp_t'{1'b0, 32'h3002, 2'd1, 4'h0, 32'h0, 1'b0});

        // Misaligned LW: error flag, no request, no stall
        m_valid = 1'b1; m_mem_op = 4'd5; m_val = 32'h0006;
        w_q.push_back(w_exp_t'{32'h0, 4'h0, 1'b0});
        @(negedge clk);
        chk("mis_addr_err", 32'(m_addr_err), 32'd1);
        chk("mis_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("mis_stall", 32'(m_stall), 32'd0);
        next_cycle();
        idle_inputs();

        // Non-memory op passes ALU result and decode write enables
        m_valid = 1'b1; m_mem_op = 4'd0; m_val = 32'hDEAD_0001;
        m_write_enable = 4'b0011; m_pc = 32'h0000_0400;
        w_q.push_back(w_exp_t'{32'hDEAD_0001, 4'b0011, 1'b1});
        @(negedge clk);
        chk("alu_stall", 32'(m_stall), 32'd0);
        chk("alu_pc", W_pc, 32'h0000_0400);
        next_cycle();
        idle_inputs();

        // LW accepted, flushed in WAIT, response drained two cycles later
        m_valid = 1'b1; m_mem_op = 4'd5; m_val = 32'h100; dresp_addr_ok = 1'b1;
        req_q.push_back(req_exp_t'{1'b0, 32'h100, 2'd2, 4'h0, 32'h0, 1'b0});
        @(negedge clk);
        chk("fl_issue_stall", 32'(m_stall), 32'd1);
        next_cycle();
        dresp_addr_ok = 1'b0; m_flush = 1'b1;
        @(negedge clk);
        chk("fl_flush_stall", 32'(m_stall), 32'd1);
        chk("fl_flush_bubble", 32'(W_bubble), 32'd1);
        next_cycle();
        m_flush = 1'b0; m_valid = 1'b0;
        @(negedge clk);
        chk("fl_drain_stall", 32'(m_stall), 32'd1);
        next_cycle();
        dresp_data_ok = 1'b1; dresp_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("fl_drain_bubble", 32'(W_bubble), 32'd1);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("fl_after_stall", 32'(m_stall), 32'd0);
        chk("fl_after_dreq", 32'(dreq_valid), 32'd0);
        next_cycle();
        quick_op(4'd2, 32'h7, 32'h0, 32'h1122_3344,
                 w_exp_t'{32'h0000_0011, 4'hF, 1'b1},
                 req_exp_t'{1'b0, 32'h7, 2'd0, 4'h0, 32'h0, 1'b0});

        // Reset asserted while a load waits for data
        m_valid = 1'b1; m_mem_op = 4'd5; m_val = 32'h200; dresp_addr_ok = 1'b1;
        req_q.push_back(req_exp_t'{1'b0, 32'h200, 2'd2, 4'h0, 32'h0, 1'b0});
        @(negedge clk);
        chk("rw_issue_stall", 32'(m_stall), 32'd1);
        next_cycle();
        idle_inputs();
        resetn = 1'b0;
        next_cycle();
        resetn = 1'b1;
        @(negedge clk);
        chk("rw_dreq_valid", 32'(dreq_valid), 32'd0);
        chk("rw_stall", 32'(m_stall), 32'd0);
        chk("rw_bubble", 32'(W_bubble), 32'd0);
        next_cycle();
        quick_op(4'd5, 32'h4000, 32'h0, 32'h1234_5678,
                 w_exp_t'{32'h1234_5678, 4'hF, 1'b1},
                 req_exp_t'{1'b0, 32'h4000, 2'd2, 4'h0, 32'h0, 1'b0});

        next_cycle();
        chk("w_queue_empty", 32'(w_q.size()), 32'd0);
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage pipeline; sits between the M pipeline register and the W pipeline register.
- Issues load/store requests on the data bus with a valid/addr_ok/data_ok handshake and extracts/extends load data.
- Stalls the pipeline while a transaction is outstanding and presents the W_* signals the W register latches.

Parameters:
- ADDR_W, 32, data bus address width.

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- m_valid  in  1  M-stage instruction valid
- m_flush  in  1  kill current M instruction (exception redirect)
- m_pc  in  32  instruction PC
- m_icode  in  6  opcode, pass-through
- m_acode  in  6  function code, pass-through
- m_val  in  32  ALU result / effective address
- m_val2  in  32  store data (rt)
- m_dst  in  5  destination register
- m_write_enable  in  4  register byte enables from decode
- m_mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
- dreq_valid  out  1  request valid
- dreq_write  out  1  1 store, 0 load
- dreq_addr  out  ADDR_W  byte address
- dreq_size  out  2  0 byte, 1 half, 2 word
- dreq_strobe  out  4  store byte strobes (0 for loads)
- dreq_data  out  32  store data, lane-replicated
- dresp_addr_ok  in  1  request accepted
- dresp_data_ok  in  1  response valid
- dresp_data  in  32  load word
- m_stall  out  1  hold F/D/E/M registers
- W_bubble  out  1  insert bubble into W register
- m_addr_err  out  1  misaligned access, one-cycle indication
- W_val3, W_pc  out  32  to W register
- W_acode, W_icode  out  6
- W_dst  out  5
- W_write_enable  out  4

Behaviour:
- Reset: resetn is synchronous, active-low; clock clk. On reset: state=IDLE, dreq_valid=0, m_stall=0, W_bubble=0, m_addr_err=0, load capture register=0.
- States: IDLE, REQ (valid held, awaiting addr_ok), WAIT (accepted, awaiting data_ok), DRAIN (flushed while outstanding; discard response).
- Active mem op: m_valid && m_mem_op in 1..8 && !m_flush && aligned.
- Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0.
  - On misalignment: m_addr_err=1, no request, W_write_enable=0, no stall.
- IDLE with an active op: dreq_valid=1 combinationally in the same cycle.
  - addr_ok && data_ok in the same cycle: complete, no stall.
  - addr_ok only: go to WAIT.
  - Neither: go to REQ.
  - m_stall=1 unless complete.
- REQ: hold dreq_valid and all request fields stable until addr_ok.
  - addr_ok with data_ok: complete, return to IDLE.
  - addr_ok without data_ok: go to WAIT.
- WAIT: dreq_valid=0; on data_ok, complete and return to IDLE.
- Completion cycle: m_stall=0; W_* carry the result.
- While m_stall=1: W_bubble=1.
- m_flush in IDLE/REQ: drop dreq_valid, return to IDLE.
  - Exception: in REQ, an addr_ok in the same cycle sends the FSM to DRAIN.
- m_flush in WAIT: go to DRAIN.
- DRAIN: m_stall=1 until data_ok, then IDLE; dresp_data is discarded. W_bubble=1 throughout.
- Store encoding:
  - SB: strobe=4'b0001<<addr[1:0], data={4{val2[7:0]}}.
  - SH: strobe=4'b0011<<{addr[1],1'b0}, data={2{val2[15:0]}}.
  - SW: strobe=4'b1111, data=val2.
- dreq_addr=m_val for all requests.
- Load result: select the byte/half lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW full word. W_val3=result, W_write_enable=4'b1111.
- Stores: W_write_enable=0.
- Non-memory ops: W_val3=m_val, W_write_enable=m_write_enable.
- !m_valid or m_flush: W_write_enable=0.
- W_pc/W_icode/W_acode/W_dst pass through combinationally.

Test Plan:
- LB at addr 0x1003, dresp_data=0x80FF_FF7F, addr_ok and data_ok same cycle -> W_val3=0xFFFFFF80, W_write_enable=4'hF, m_stall never 1.
- LHU at 0x2002, addr_ok delayed 2 cycles, data_ok 3 cycles later with 0xBEEF1234 -> dreq_valid held 3 cycles with stable fields; m_stall=1 and W_bubble=1 for 5 cycles; W_val3=0x0000BEEF.
- SB at 0x10, val2=0x000000AB -> dreq_strobe=4'b0001, dreq_data=0xABABABAB, dreq_write=1, W_write_enable=0.
- LW at 0x0006 -> m_addr_err=1, dreq_valid=0, W_write_enable=0, no stall.
- LW accepted, m_flush raised in WAIT, data_ok 2 cycles later -> DRAIN; m_stall=1 until data_ok, data discarded, then IDLE.
- resetn low while in WAIT -> next cycle state=IDLE, dreq_valid=0, m_stall=0.
